// File: rtl/fifo_ptr_pkg.sv
// Shared definitions for the FIFO pointer controllers (write_pointer, read_pointer).
// Holds the default address width, the depth derivation and the fifo_state encoding.
package fifo_ptr_pkg;

  // Default address width; depth is always a power of two.
  localparam int ADDR_W_DEF = 10;

  // Depth derived from an address width.
  function automatic int depth_of(input int aw);
    return 32'sd1 << aw;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

  // fifo_state encoding as seen on the output port.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY   = ST_EMPTY,
    S_PARTIAL = ST_PARTIAL,
    S_FULL    = ST_FULL
  } fifo_state_e;

endpackage

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray converter, width-parameterised.
// Used by write_pointer (WPTR_GRAY_EN builds) and later by read_pointer.
module bin2gray #(
  parameter int W = 11
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/write_pointer.sv
// Write-side pointer controller for the single-clock FIFO.
// Qualifies producer writes against fullness, advances the extended write pointer,
// derives occupancy / full / almost-full against the read pointer, tracks sticky
// overflow and a registered EMPTY/PARTIAL/FULL state.
// Optional build macro: WPTR_GRAY_EN adds a registered Gray image of wptr (wptr_gray).
module write_pointer
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AFULL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr,
  input  logic              clr_ovf,
  output logic [ADDR_W:0]   wptr,
  output logic              fifo_we,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  output logic [1:0]        fifo_state
`ifdef WPTR_GRAY_EN
  ,
  output logic [ADDR_W:0]   wptr_gray
`endif
);

  // Occupancy value that means "full": MSB set, address bits zero.
  localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_THR = DEPTH_C - (ADDR_W+1)'(AFULL_MARGIN);
  localparam logic [ADDR_W:0] ONE_C     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_C    = {(ADDR_W+1){1'b0}};

  logic [ADDR_W:0] wptr_r;
  logic [ADDR_W:0] wptr_next_s;
  logic [ADDR_W:0] occ_next_s;
  logic            full_s;
  logic            ovf_r;
  fifo_state_e     state_r;
  fifo_state_e     state_next_s;

  // Full is judged on current pointers only, so a same-cycle read never rescues a write.
  assign wr_count   = wptr_r - rptr;
  assign full_s     = (wptr_r[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr_r[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign fifo_full  = full_s;
  assign fifo_afull = (wr_count >= AFULL_THR);
  assign fifo_we    = wr & ~full_s & ~rst;

  assign wptr       = wptr_r;
  assign overflow   = ovf_r;
  assign fifo_state = state_r;

  // Pointer after this edge, and the occupancy it implies against the current read pointer.
  always_comb begin
    wptr_next_s = wptr_r;
    if (fifo_we) begin
      wptr_next_s = wptr_r + ONE_C;
    end else begin
      wptr_next_s = wptr_r;
    end
    occ_next_s = wptr_next_s - rptr;
  end

  // Write pointer: advances on every accepted write, wraps naturally through the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= ZERO_C;
    end else begin
      wptr_r <= wptr_next_s;
    end
  end

  // Sticky overflow: a dropped write sets it; a same-edge set beats clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (wr && full_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // State register for the occupancy FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state from next-cycle occupancy; EMPTY never jumps straight to FULL.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_EMPTY: begin
        if (occ_next_s != ZERO_C) begin
          state_next_s = S_PARTIAL;
        end else begin
          state_next_s = S_EMPTY;
        end
      end
      S_PARTIAL, S_FULL: begin
        if (occ_next_s == DEPTH_C) begin
          state_next_s = S_FULL;
        end else if (occ_next_s == ZERO_C) begin
          state_next_s = S_EMPTY;
        end else begin
          state_next_s = S_PARTIAL;
        end
      end
      default: begin
        state_next_s = S_EMPTY;
      end
    endcase
  end

`ifdef WPTR_GRAY_EN
  logic [ADDR_W:0] gray_s;
  logic [ADDR_W:0] gray_r;

  bin2gray #(
    .W(ADDR_W + 1)
  ) u_bin2gray (
    .bin  (wptr_r),
    .gray (gray_s)
  );

  // Gray image of the updated pointer, one cycle behind wptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_r <= ZERO_C;
    end else begin
      gray_r <= gray_s;
    end
  end

  assign wptr_gray = gray_r;
`endif

endmodule

// File: tb/tb_write_pointer.sv
// Self-checking bench for write_pointer: directed phases (reset, fill, overflow,
// concurrent read at full, wrap) followed by randomized traffic, all checked
// against a model that counts total words written and read as plain integers.
module tb_write_pointer;

  localparam int AW     = 10;
  localparam int DEPTH  = 1024;
  localparam int MOD    = 2048;
  localparam int MARGIN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [AW:0]   rptr;
  logic          clr_ovf;
  logic [AW:0]   wptr;
  logic          fifo_we;
  logic          fifo_full;
  logic          fifo_afull;
  logic [AW:0]   wr_count;
  logic          overflow;
  logic [1:0]    fifo_state;
`ifdef WPTR_GRAY_EN
  logic [AW:0]   wptr_gray;
  logic [AW:0]   prev_gray;
`endif

  write_pointer #(
    .ADDR_W       (AW),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .rptr       (rptr),
    .clr_ovf    (clr_ovf),
    .wptr       (wptr),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .wr_count   (wr_count),
    .overflow   (overflow),
    .fifo_state (fifo_state)
`ifdef WPTR_GRAY_EN
    ,
    .wptr_gray  (wptr_gray)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: totals of words written / read, sticky flag, expected state.
  int   w_total;
  int   r_total;
  bit   m_ovf;
  int   m_st;
  int   m_gray;
  logic [1:0] last_st;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input int occ);
    if (occ == 0) return 0;
    if (occ == DEPTH) return 2;
    return 1;
  endfunction

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // One clock cycle: drive inputs, check at negedge, update model at posedge.
  // rd_req means read_pointer advances at this edge (only if the FIFO is not empty).
  task automatic step(input bit w, input bit rd_req, input bit clr, input bit r);
    int occ;
    bit we;
    wr      = w;
    clr_ovf = clr;
    rst     = r;
    @(negedge clk);
    occ = w_total - r_total;
    we  = w && (occ < DEPTH) && !r;
    check_eq("fifo_we",  {31'd0, fifo_we},    {31'd0, we});
    check_eq("wptr",     {21'd0, wptr},       w_total % MOD);
    check_eq("wr_count", {21'd0, wr_count},   occ);
    check_eq("full",     {31'd0, fifo_full},  {31'd0, (occ == DEPTH)});
    check_eq("afull",    {31'd0, fifo_afull}, {31'd0, (occ >= DEPTH - MARGIN)});
    check_eq("overflow", {31'd0, overflow},   {31'd0, m_ovf});
    check_eq("state",    {30'd0, fifo_state}, m_st);
    check_eq("empty_to_full", {31'd0, (last_st == 2'd0 && fifo_state == 2'd2)}, 32'd0);
    last_st = fifo_state;
`ifdef WPTR_GRAY_EN
    check_eq("gray",      {21'd0, wptr_gray}, m_gray);
    check_eq("gray_step", (($countones(wptr_gray ^ prev_gray) <= 1) ? 32'd1 : 32'd0), 32'd1);
    prev_gray = wptr_gray;
`endif
    @(posedge clk);
    if (r) begin
      w_total = 0;
      r_total = 0;
      m_ovf   = 1'b0;
      m_st    = 0;
      m_gray  = 0;
    end else begin
      m_gray = to_gray(w_total % MOD);
      if (w && occ == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (we) w_total++;
      m_st = classify(w_total - r_total);
      if (rd_req && occ > 0) r_total++;
    end
    #1;
    rptr = (AW+1)'(r_total % MOD);
  endtask

  initial begin
    int guard;
    int pw;
    int pr;
    rst     = 1'b1;
    wr      = 1'b1;
    clr_ovf = 1'b0;
    rptr    = '0;
    w_total = 0;
    r_total = 0;
    m_ovf   = 1'b0;
    m_st    = 0;
    m_gray  = 0;
    last_st = 2'd0;
`ifdef WPTR_GRAY_EN
    prev_gray = '0;
`endif
    @(posedge clk);
    #1;

    // Reset held two cycles with wr=1: no write may get through.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Fill from empty with no reads.
    guard = 0;
    while ((w_total - r_total) < DEPTH && guard < 1100) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check_eq("fill_reached_full", {31'd0, fifo_full}, 32'd1);

    // Overflow: three more writes while full, then clear with wr low.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Set beats clear on the same edge.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Concurrent write and read at full: dropped now, accepted next cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap: reset mid-operation, then stream with the reader one behind.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1023; i++) begin
      step(1'b1, (i > 0), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with varying write/read pressure.
    pw = 50;
    pr = 50;
    for (int i = 0; i < 6000; i++) begin
      if (i % 500 == 0) begin
        pw = $urandom_range(100);
        pr = $urandom_range(100);
      end
      step(($urandom_range(99) < pw), ($urandom_range(99) < pr),
           ($urandom_range(99) < 5), ($urandom_range(999) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
